mac_stim_seq: RTL and testbench
===============================

# mac_stim_seq

Synthesizable, parametrised stimulus sequencer for the floating-point MAC datapath (A + B × C). It replays three stimulus classes (one directed basic vector, LFSR-driven bounded random vectors, and the full edge-pattern cross product) over a valid/ready handshake. It sits between the bench/FPGA controller and the MAC input port, so the same stimulus runs in simulation and on silicon for any IEEE-754 width.

## Interface
- PARM_XLEN, 32, operand width
- PARM_EXP, 8, exponent field width
- PARM_MANT, 23, mantissa field width (PARM_XLEN = 1 + PARM_EXP + PARM_MANT)
- PARM_BIAS, 127, exponent bias
- PARM_NUM_RAND, 20, random vectors per run (1..65535)
- PARM_SEED, 32'hACE12024, LFSR seed (0 is loaded as 1)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; synchronous, active-high
- start_i  in  1  begin a run; sampled only in IDLE
- mode_i  in  2  0 BASIC, 1 RANDOM, 2 EDGE, 3 ALL; sampled with start_i
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse after last accepted vector
- valid_o  out  1  A_o/B_o/C_o hold a vector
- ready_i  in  1  consumer accepts the vector this cycle
- A_o, B_o, C_o  out  PARM_XLEN  operands
- vec_idx_o  out  16  index of the current vector within the current phase

## Operation
- FSM states: IDLE, BASIC, RAND, EDGE, DONE.
- IDLE + start_i: go to BASIC (modes 0 and 3), RAND (mode 1), or EDGE (mode 2). Mode is latched.
- BASIC: one vector, A=+1.5, B=+2.0, C=+3.0, encoded from PARM_EXP/PARM_MANT/PARM_BIAS. After the transfer: mode 3 goes to RAND, otherwise DONE.
- RAND: PARM_NUM_RAND vectors.
  - 32-bit Galois LFSR, taps 32'h80200003, shift right.
  - Per operand: sign = s[31]; exponent = PARM_BIAS−9+s[30:27]; mantissa = low PARM_MANT bits of {s,s}.
  - A, B, C use LFSR states step+1, +2, +3. The register advances by 3 on each transfer.
  - Resulting |x| < 128, never NaN/Inf/subnormal.
  - After the last transfer: mode 3 goes to EDGE, otherwise DONE.
- EDGE: 16-entry pattern table, indices i (A), j (B), k (C). k increments fastest. 4096 vectors.
  - Table order: +0, −0, largest subnormal, smallest normal, +max, −max, +Inf, −Inf, qNaN (mantissa MSB set), sNaN (mantissa bit MSB−1 set), +1, −1, +2, −2, +1.5, +2^−PARM_MANT.
  - All entries are built from field parameters.
  - After (15,15,15) is transferred: DONE.
- DONE: done_o=1 for one cycle, busy_o=0, then IDLE.
- vec_idx_o resets to 0 at each phase entry and increments on each transfer. In EDGE it equals {i,j,k}.
- start_i is ignored outside IDLE. mode_i changes mid-run have no effect.

## Timing
- Reset values: busy_o=0, done_o=0, valid_o=0, A_o=B_o=C_o=0, vec_idx_o=0, state IDLE, LFSR=PARM_SEED.
- start_i high at edge t: busy_o and valid_o high from t+1, with the first vector present at t+1.
- Transfer = valid_o && ready_i at a rising edge. The next vector is presented the following cycle with no bubble, including across phase changes in mode 3.
- While valid_o && !ready_i, all outputs and the LFSR are held stable.
- Last transfer at edge t: at t+1, valid_o=0, busy_o=0, done_o=1. At t+2, done_o=0. A new start_i is accepted at t+2 or later.
- rst mid-run: full reset values on the next cycle, no done_o pulse, LFSR reseeded. A rerun is therefore bit-identical.
- Run lengths in transfers: BASIC 1, RANDOM PARM_NUM_RAND, EDGE 4096, ALL 4097+PARM_NUM_RAND.

## Configuration
- MAC_STIM_EDGE_EN defined: edge table and EDGE state are compiled in, with the behaviour above.
- MAC_STIM_EDGE_EN undefined: no table and no EDGE state.
  - Mode 2: busy_o for one cycle, then a done_o pulse with zero transfers.
  - Mode 3: runs BASIC then RAND, then DONE.

## Structure
- Package mac_stim_pkg holds:
  - state enum;
  - mode enum;
  - LFSR tap constant;
  - edge pattern index constants;
  - function fp_pack(sign, exp, mant) parametrised by field widths.
- One sub-module: mac_stim_lfsr (seed load, hold, 3-step advance, step+1/+2/+3 outputs).

## Test plan
- Mode 0, ready_i=1, PARM_XLEN=32 -> one transfer A=3FC00000, B=40000000, C=40400000. done_o high 2 cycles after start_i.
- Mode 1, PARM_NUM_RAND=20, ready_i toggling 1/0 -> exactly 20 transfers matching a reference-model LFSR with seed ACE12024. All exponent fields in [118,133]. Operands stable while stalled.
- Mode 2, ready_i=1 -> 4096 transfers. First (00000000,00000000,00000000), transfer 17 (00000000,80000000,00000000), last (34000000,34000000,34000000).
- Mode 3 -> 4117 transfers, no valid_o gap at the BASIC->RAND and RAND->EDGE boundaries, one done_o pulse.
- rst asserted at transfer 7 of mode 1, then restart -> outputs zero the next cycle, and the rerun sequence is identical to the first run.
- PARM_XLEN=16 (EXP 5, MANT 10, BIAS 15), mode 2 -> +Inf=7C00, qNaN=7E00, max=7BFF, epsilon=1400.

Source files
------------

// File: rtl/mac_stim_pkg.sv
// Shared types and helpers for the MAC stimulus sequencer: FSM/mode enums,
// LFSR taps, edge-pattern table indices and a width-generic IEEE-754 packer.
package mac_stim_pkg;

`ifdef MAC_STIM_EDGE_EN
  typedef enum logic [2:0] {ST_IDLE, ST_BASIC, ST_RAND, ST_EDGE, ST_DONE} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_BASIC, ST_RAND, ST_DONE} state_t;
`endif

  typedef enum logic [1:0] {MODE_BASIC, MODE_RANDOM, MODE_EDGE, MODE_ALL} mode_t;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  localparam logic [3:0] EDGE_POS_ZERO  = 4'd0;
  localparam logic [3:0] EDGE_NEG_ZERO  = 4'd1;
  localparam logic [3:0] EDGE_MAX_SUB   = 4'd2;
  localparam logic [3:0] EDGE_MIN_NORM  = 4'd3;
  localparam logic [3:0] EDGE_POS_MAX   = 4'd4;
  localparam logic [3:0] EDGE_NEG_MAX   = 4'd5;
  localparam logic [3:0] EDGE_POS_INF   = 4'd6;
  localparam logic [3:0] EDGE_NEG_INF   = 4'd7;
  localparam logic [3:0] EDGE_QNAN      = 4'd8;
  localparam logic [3:0] EDGE_SNAN      = 4'd9;
  localparam logic [3:0] EDGE_POS_ONE   = 4'd10;
  localparam logic [3:0] EDGE_NEG_ONE   = 4'd11;
  localparam logic [3:0] EDGE_POS_TWO   = 4'd12;
  localparam logic [3:0] EDGE_NEG_TWO   = 4'd13;
  localparam logic [3:0] EDGE_ONE_HALF  = 4'd14;
  localparam logic [3:0] EDGE_EPSILON   = 4'd15;

  // Fields are masked to their widths; callers truncate the result to XLEN.
  function automatic logic [63:0] fp_pack(input logic sign, input logic [31:0] exp,
                                          input logic [63:0] mant,
                                          input int unsigned exp_w, input int unsigned mant_w);
    logic [63:0] e_mask;
    logic [63:0] m_mask;
    e_mask = (64'd1 << exp_w) - 64'd1;
    m_mask = (64'd1 << mant_w) - 64'd1;
    return ({63'd0, sign} << (exp_w + mant_w)) |
           (({32'd0, exp} & e_mask) << mant_w) |
           (mant & m_mask);
  endfunction

endpackage

// File: rtl/mac_stim_seq_if.sv
// Valid/ready operand bus between the stimulus sequencer and the MAC input port.
interface mac_stim_seq_if #(parameter int unsigned XLEN = 32);
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] A_o;
  logic [XLEN-1:0] B_o;
  logic [XLEN-1:0] C_o;
  logic [15:0]     vec_idx_o;

  modport master (output valid_o, A_o, B_o, C_o, vec_idx_o, input ready_i);
  modport slave  (input valid_o, A_o, B_o, C_o, vec_idx_o, output ready_i);
endinterface

// File: rtl/mac_stim_lfsr.sv
// 32-bit right-shifting Galois LFSR exposing the next three states; advancing
// jumps by three steps so each random vector consumes fresh states.
module mac_stim_lfsr
  import mac_stim_pkg::*;
#(
  parameter logic [31:0] PARM_SEED = 32'hACE12024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [31:0] step1,
  output logic [31:0] step2,
  output logic [31:0] step3
);

  localparam logic [31:0] SEED = (PARM_SEED == '0) ? 32'd1 : PARM_SEED;

  logic [31:0] state;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'd0);
  endfunction

  assign step1 = lfsr_step(state);
  assign step2 = lfsr_step(step1);
  assign step3 = lfsr_step(step2);

  always_ff @(posedge clk) begin
    if (rst)          state <= SEED;
    else if (advance) state <= step3;
  end

endmodule

// File: rtl/mac_stim_seq.sv
// Stimulus sequencer for the FP MAC (A + B*C): basic, LFSR-random and edge-pattern
// vectors over valid/ready. Define MAC_STIM_EDGE_EN to compile in the edge table.
module mac_stim_seq
  import mac_stim_pkg::*;
#(
  parameter int unsigned PARM_XLEN     = 32,
  parameter int unsigned PARM_EXP      = 8,
  parameter int unsigned PARM_MANT     = 23,
  parameter int unsigned PARM_BIAS     = 127,
  parameter int unsigned PARM_NUM_RAND = 20,
  parameter logic [31:0] PARM_SEED     = 32'hACE12024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  output logic        busy_o,
  output logic        done_o,
  mac_stim_seq_if.master bus
);

  localparam logic [63:0] MANT_MSB  = 64'd1 << (PARM_MANT - 1);
  localparam logic [15:0] LAST_RAND = 16'(PARM_NUM_RAND - 1);
  localparam logic [PARM_XLEN-1:0] BASIC_A =
    PARM_XLEN'(fp_pack(1'b0, PARM_BIAS, MANT_MSB, PARM_EXP, PARM_MANT));
  localparam logic [PARM_XLEN-1:0] BASIC_B =
    PARM_XLEN'(fp_pack(1'b0, PARM_BIAS + 1, 64'd0, PARM_EXP, PARM_MANT));
  localparam logic [PARM_XLEN-1:0] BASIC_C =
    PARM_XLEN'(fp_pack(1'b0, PARM_BIAS + 1, MANT_MSB, PARM_EXP, PARM_MANT));

`ifdef MAC_STIM_EDGE_EN
  localparam state_t ALL_AFTER_RAND = ST_EDGE;
  localparam logic [31:0] EXP_ONES  = (32'd1 << PARM_EXP) - 32'd1;
  localparam logic [63:0] MANT_ONES = (64'd1 << PARM_MANT) - 64'd1;
  localparam logic [63:0] MANT_SNAN = 64'd1 << (PARM_MANT - 2);

  function automatic logic [PARM_XLEN-1:0] edge_pat(input logic [3:0] idx);
    logic [63:0] p;
    case (idx)
      EDGE_POS_ZERO: p = fp_pack(1'b0, 32'd0, 64'd0, PARM_EXP, PARM_MANT);
      EDGE_NEG_ZERO: p = fp_pack(1'b1, 32'd0, 64'd0, PARM_EXP, PARM_MANT);
      EDGE_MAX_SUB:  p = fp_pack(1'b0, 32'd0, MANT_ONES, PARM_EXP, PARM_MANT);
      EDGE_MIN_NORM: p = fp_pack(1'b0, 32'd1, 64'd0, PARM_EXP, PARM_MANT);
      EDGE_POS_MAX:  p = fp_pack(1'b0, EXP_ONES - 32'd1, MANT_ONES, PARM_EXP, PARM_MANT);
      EDGE_NEG_MAX:  p = fp_pack(1'b1, EXP_ONES - 32'd1, MANT_ONES, PARM_EXP, PARM_MANT);
      EDGE_POS_INF:  p = fp_pack(1'b0, EXP_ONES, 64'd0, PARM_EXP, PARM_MANT);
      EDGE_NEG_INF:  p = fp_pack(1'b1, EXP_ONES, 64'd0, PARM_EXP, PARM_MANT);
      EDGE_QNAN:     p = fp_pack(1'b0, EXP_ONES, MANT_MSB, PARM_EXP, PARM_MANT);
      EDGE_SNAN:     p = fp_pack(1'b0, EXP_ONES, MANT_SNAN, PARM_EXP, PARM_MANT);
      EDGE_POS_ONE:  p = fp_pack(1'b0, PARM_BIAS, 64'd0, PARM_EXP, PARM_MANT);
      EDGE_NEG_ONE:  p = fp_pack(1'b1, PARM_BIAS, 64'd0, PARM_EXP, PARM_MANT);
      EDGE_POS_TWO:  p = fp_pack(1'b0, PARM_BIAS + 1, 64'd0, PARM_EXP, PARM_MANT);
      EDGE_NEG_TWO:  p = fp_pack(1'b1, PARM_BIAS + 1, 64'd0, PARM_EXP, PARM_MANT);
      EDGE_ONE_HALF: p = fp_pack(1'b0, PARM_BIAS, MANT_MSB, PARM_EXP, PARM_MANT);
      default:       p = fp_pack(1'b0, PARM_BIAS - PARM_MANT, 64'd0, PARM_EXP, PARM_MANT);
    endcase
    return PARM_XLEN'(p);
  endfunction
`else
  localparam state_t ALL_AFTER_RAND = ST_DONE;
`endif

  // Exponent spans BIAS-9..BIAS+6, keeping every random operand finite and normal.
  function automatic logic [PARM_XLEN-1:0] rand_op(input logic [31:0] s);
    return PARM_XLEN'(fp_pack(s[31], PARM_BIAS - 32'd9 + {28'd0, s[30:27]}, {s, s},
                              PARM_EXP, PARM_MANT));
  endfunction

  state_t                state_q, state_d;
  mode_t                 mode_q, mode_d;
  logic [15:0]           idx_q, idx_d;
  logic                  advance, valid, busy, done;
  logic [31:0]           s1, s2, s3;
  logic [PARM_XLEN-1:0]  a, b, c;

  mac_stim_lfsr #(.PARM_SEED(PARM_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .step1   (s1),
    .step2   (s2),
    .step3   (s3)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BASIC;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    valid   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    advance = 1'b0;
    a       = '0;
    b       = '0;
    c       = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d = mode_t'(mode_i);
          idx_d  = '0;
          case (mode_t'(mode_i))
            MODE_RANDOM: state_d = ST_RAND;
`ifdef MAC_STIM_EDGE_EN
            MODE_EDGE:   state_d = ST_EDGE;
`endif
            default:     state_d = ST_BASIC;
          endcase
        end
      end
      ST_BASIC: begin
        busy = 1'b1;
        // Mode 2 only lands here without the edge table: one empty busy cycle.
        if (mode_q == MODE_EDGE) begin
          state_d = ST_DONE;
        end else begin
          valid = 1'b1;
          a = BASIC_A;
          b = BASIC_B;
          c = BASIC_C;
          if (bus.ready_i) state_d = (mode_q == MODE_ALL) ? ST_RAND : ST_DONE;
        end
      end
      ST_RAND: begin
        busy  = 1'b1;
        valid = 1'b1;
        a = rand_op(s1);
        b = rand_op(s2);
        c = rand_op(s3);
        if (bus.ready_i) begin
          advance = 1'b1;
          if (idx_q == LAST_RAND) begin
            idx_d   = '0;
            state_d = (mode_q == MODE_ALL) ? ALL_AFTER_RAND : ST_DONE;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
`ifdef MAC_STIM_EDGE_EN
      ST_EDGE: begin
        busy  = 1'b1;
        valid = 1'b1;
        a = edge_pat(idx_q[11:8]);
        b = edge_pat(idx_q[7:4]);
        c = edge_pat(idx_q[3:0]);
        if (bus.ready_i) begin
          if (idx_q[11:0] == 12'hFFF) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
`endif
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o        = busy;
  assign done_o        = done;
  assign bus.valid_o   = valid;
  assign bus.A_o       = a;
  assign bus.B_o       = b;
  assign bus.C_o       = c;
  assign bus.vec_idx_o = idx_q;

endmodule

// File: tb/tb_mac_stim_seq.sv
// Directed bench for mac_stim_seq: table of whole runs plus hand sequences for
// reset mid-run and the mode-3 phase boundaries, on 32- and 16-bit instances.
module tb_mac_stim_seq;

  localparam logic [31:0] SEED = 32'hACE12024;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start32 = 1'b0;
  logic       start16 = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       busy32, done32, busy16, done16;

  mac_stim_seq_if #(.XLEN(32)) b32();
  mac_stim_seq_if #(.XLEN(16)) b16();
  assign b32.ready_i = ready;
  assign b16.ready_i = ready;

  mac_stim_seq #(.PARM_XLEN(32), .PARM_EXP(8), .PARM_MANT(23), .PARM_BIAS(127),
                 .PARM_NUM_RAND(20), .PARM_SEED(SEED)) dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .mode_i(mode),
    .busy_o(busy32), .done_o(done32), .bus(b32));

  mac_stim_seq #(.PARM_XLEN(16), .PARM_EXP(5), .PARM_MANT(10), .PARM_BIAS(15),
                 .PARM_NUM_RAND(3), .PARM_SEED(SEED)) dut16 (
    .clk(clk), .rst(rst), .start_i(start16), .mode_i(mode),
    .busy_o(busy16), .done_o(done16), .bus(b16));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit          sel16 = 1'b0;
  logic        v_valid, v_busy, v_done;
  logic [31:0] v_a, v_b, v_c;
  logic [15:0] v_idx;

  always_comb begin
    if (sel16) begin
      v_valid = b16.valid_o; v_busy = busy16; v_done = done16; v_idx = b16.vec_idx_o;
      v_a = {16'd0, b16.A_o}; v_b = {16'd0, b16.B_o}; v_c = {16'd0, b16.C_o};
    end else begin
      v_valid = b32.valid_o; v_busy = busy32; v_done = done32; v_idx = b32.vec_idx_o;
      v_a = b32.A_o; v_b = b32.B_o; v_c = b32.C_o;
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  // fp32 random operand: exponent 118 + s[30:27], mantissa = s[22:0].
  function automatic logic [31:0] rmk(input logic [31:0] s);
    return {s[31], 8'd118 + {4'd0, s[30:27]}, s[22:0]};
  endfunction

  logic [31:0] qa[$], qb[$], qc[$];
  logic [15:0] qi[$];
  int n_xfer, done_cyc, n_done, gaps, stall_bad;
  logic busy1, valid1;
  logic [31:0] ms;

  task automatic run(input bit s16, input logic [1:0] m, input bit tog, input int max_cyc);
    logic pv, pr;
    logic [31:0] pa, pb, pc;
    logic [15:0] pi;
    bit seen_valid;
    qa.delete(); qb.delete(); qc.delete(); qi.delete();
    n_xfer = 0; done_cyc = -1; n_done = 0; gaps = 0; stall_bad = 0;
    pv = 1'b0; pr = 1'b0; pa = '0; pb = '0; pc = '0; pi = '0; seen_valid = 1'b0;
    sel16 = s16;
    mode = m;
    ready = 1'b1;
    if (s16) start16 = 1'b1; else start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; start16 = 1'b0;
    mode = ~m;
    for (int c = 1; c <= max_cyc; c++) begin
      if (c == 1) begin busy1 = v_busy; valid1 = v_valid; end
      if (pv && !pr && (!v_valid || v_a !== pa || v_b !== pb || v_c !== pc || v_idx !== pi))
        stall_bad++;
      if (v_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc > 0 && c == done_cyc + 1) break;
      if (seen_valid && done_cyc < 0 && !v_valid) gaps++;
      if (v_valid) seen_valid = 1'b1;
      if (c == 3 && v_busy) begin
        if (s16) start16 = 1'b1; else start32 = 1'b1;
      end
      ready = tog ? logic'(c % 2 == 1) : 1'b1;
      if (v_valid && ready) begin
        qa.push_back(v_a); qb.push_back(v_b); qc.push_back(v_c); qi.push_back(v_idx);
        n_xfer++;
      end
      pv = v_valid; pr = ready; pa = v_a; pb = v_b; pc = v_c; pi = v_idx;
      @(posedge clk); #1;
      start32 = 1'b0; start16 = 1'b0;
    end
  endtask

  task automatic chk_rand(input int from, input int n, input string tag);
    int bad = 0;
    int exp_bad = 0;
    logic [31:0] s1, s2, s3;
    for (int k = 0; k < n; k++) begin
      s1 = lstep(ms); s2 = lstep(s1); s3 = lstep(s2); ms = s3;
      if (from + k >= qa.size()) begin
        bad++;
      end else begin
        if (qa[from+k] !== rmk(s1) || qb[from+k] !== rmk(s2) || qc[from+k] !== rmk(s3) ||
            qi[from+k] !== 16'(k))
          bad++;
        if (qa[from+k][30:23] < 8'd118 || qa[from+k][30:23] > 8'd133 ||
            qb[from+k][30:23] < 8'd118 || qb[from+k][30:23] > 8'd133 ||
            qc[from+k][30:23] < 8'd118 || qc[from+k][30:23] > 8'd133)
          exp_bad++;
      end
    end
    check({tag, " vectors vs model"}, bad, 0);
    check({tag, " exponent range"}, exp_bad, 0);
  endtask

  typedef struct {
    bit          s16;
    logic [1:0]  mode;
    bit          tog;
    int          xfers;
    int          done_cyc;
    logic [31:0] a0, b0, c0;
  } vec_t;

  vec_t tbl[5];
  logic [31:0] fa[$], fb[$], fc[$];

  initial begin
    logic [31:0] t1, t2, t3;
    int cnt, mism;
    t1 = lstep(SEED); t2 = lstep(t1); t3 = lstep(t2);
    tbl[0] = '{1'b0, 2'd0, 1'b0, 1, 2, 32'h3FC00000, 32'h40000000, 32'h40400000};
    tbl[1] = '{1'b0, 2'd1, 1'b1, 20, 40, rmk(t1), rmk(t2), rmk(t3)};
    tbl[3] = '{1'b1, 2'd0, 1'b0, 1, 2, 32'h00003E00, 32'h00004000, 32'h00004200};
`ifdef MAC_STIM_EDGE_EN
    tbl[2] = '{1'b0, 2'd2, 1'b0, 4096, 4097, 32'h0, 32'h0, 32'h0};
    tbl[4] = '{1'b1, 2'd2, 1'b0, 4096, 4097, 32'h0, 32'h0, 32'h0};
`else
    tbl[2] = '{1'b0, 2'd2, 1'b0, 0, 2, 32'h0, 32'h0, 32'h0};
    tbl[4] = '{1'b1, 2'd2, 1'b0, 0, 2, 32'h0, 32'h0, 32'h0};
`endif

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy32, 0);
    check("reset done", done32, 0);
    check("reset valid", b32.valid_o, 0);
    check("reset A", b32.A_o, 0);
    check("reset B", b32.B_o, 0);
    check("reset C", b32.C_o, 0);
    check("reset idx", b32.vec_idx_o, 0);
    rst = 1'b0;
    ms = SEED;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run(tbl[i].s16, tbl[i].mode, tbl[i].tog, 4300);
      check($sformatf("v%0d transfers", i), n_xfer, tbl[i].xfers);
      check($sformatf("v%0d done cycle", i), done_cyc, tbl[i].done_cyc);
      check($sformatf("v%0d done pulses", i), n_done, 1);
      check($sformatf("v%0d busy first cycle", i), busy1, 1);
      check($sformatf("v%0d valid first cycle", i), valid1, tbl[i].xfers > 0);
      check($sformatf("v%0d stall stability", i), stall_bad, 0);
      check($sformatf("v%0d valid gaps", i), gaps, 0);
      if (tbl[i].xfers > 0) begin
        check($sformatf("v%0d first A", i), qa[0], tbl[i].a0);
        check($sformatf("v%0d first B", i), qb[0], tbl[i].b0);
        check($sformatf("v%0d first C", i), qc[0], tbl[i].c0);
      end
      if (i == 1) chk_rand(0, 20, "rand");
`ifdef MAC_STIM_EDGE_EN
      if (i == 2) begin
        check("edge17 A", qa[16], 32'h0);
        check("edge17 B", qb[16], 32'h80000000);
        check("edge17 C", qc[16], 32'h0);
        check("edge17 idx", qi[16], 16'h0010);
        check("edge last A", qa[4095], 32'h34000000);
        check("edge last B", qb[4095], 32'h34000000);
        check("edge last C", qc[4095], 32'h34000000);
        check("edge last idx", qi[4095], 16'h0FFF);
        check("edge maxsub", qc[2], 32'h007FFFFF);
        check("edge minnorm", qc[3], 32'h00800000);
      end
      if (i == 4) begin
        check("fp16 +max", qc[4], 32'h7BFF);
        check("fp16 +inf", qc[6], 32'h7C00);
        check("fp16 qnan", qc[8], 32'h7E00);
        check("fp16 snan", qc[9], 32'h7D00);
        check("fp16 epsilon", qc[15], 32'h1400);
      end
`endif
    end

    // Reset asserted on the 7th transfer of mode 1, then a clean rerun
    sel16 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fa.delete(); fb.delete(); fc.delete();
    mode = 2'd1; ready = 1'b1; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    cnt = 0;
    for (int c = 0; c < 60 && !rst; c++) begin
      if (v_valid) begin
        if (cnt == 6) rst = 1'b1;
        else begin fa.push_back(v_a); fb.push_back(v_b); fc.push_back(v_c); end
        cnt++;
      end
      @(posedge clk); #1;
    end
    check("midrst vectors before reset", fa.size(), 6);
    check("midrst valid", b32.valid_o, 0);
    check("midrst busy", busy32, 0);
    check("midrst done", done32, 0);
    check("midrst A", b32.A_o, 0);
    check("midrst B", b32.B_o, 0);
    check("midrst C", b32.C_o, 0);
    check("midrst idx", b32.vec_idx_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst no done pulse", done32, 0);
    run(1'b0, 2'd1, 1'b0, 100);
    check("rerun transfers", n_xfer, 20);
    mism = 0;
    for (int k = 0; k < fa.size(); k++)
      if (qa[k] !== fa[k] || qb[k] !== fb[k] || qc[k] !== fc[k]) mism++;
    check("rerun matches first run", mism, 0);
    ms = SEED;
    chk_rand(0, 20, "rerun");

    // Mode 3: all phases back to back
    run(1'b0, 2'd3, 1'b0, 4300);
`ifdef MAC_STIM_EDGE_EN
    check("all transfers", n_xfer, 4117);
    check("all done cycle", done_cyc, 4118);
`else
    check("all transfers", n_xfer, 21);
    check("all done cycle", done_cyc, 22);
`endif
    check("all done pulses", n_done, 1);
    check("all valid gaps", gaps, 0);
    check("all basic A", qa[0], 32'h3FC00000);
    check("all rand idx start", qi[1], 16'h0);
    chk_rand(1, 20, "all rand");
`ifdef MAC_STIM_EDGE_EN
    check("all edge idx start", qi[21], 16'h0);
    check("all edge first A", qa[21], 32'h0);
    check("all edge second C", qc[22], 32'h80000000);
    check("all edge last A", qa[4116], 32'h34000000);
    check("all edge last idx", qi[4116], 16'h0FFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
